// File: rtl/branch_cmp_sched.sv
// branch_cmp_sched: sequencer and round-robin arbiter that lets the branch unit
// and the ALU SLT/SLTU path share a single 32-bit comparator. Operands and mode
// are registered on accept, flags are sampled one cycle later, and the result is
// returned as a single-cycle response strobe with held response data.
module branch_cmp_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_req_valid,
    output logic        br_req_ready,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] br_rs1,
    input  logic [31:0] br_rs2,
    output logic        br_resp_valid,
    output logic        br_taken,
    output logic        br_illegal,
    input  logic        slt_req_valid,
    output logic        slt_req_ready,
    input  logic        slt_unsigned,
    input  logic [31:0] slt_rs1,
    input  logic [31:0] slt_rs2,
    output logic        slt_resp_valid,
    output logic [31:0] slt_result,
    output logic        cmp_brun,
    output logic [31:0] cmp_in_a,
    output logic [31:0] cmp_in_b,
    input  logic        cmp_breq,
    input  logic        cmp_brlt,
    output logic [15:0] br_taken_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // funct3 010/011 are not RV32I branches
    function automatic logic f3_illegal(input logic [2:0] f3);
        logic ill;
        case (f3)
            3'b010:  ill = 1'b1;
            3'b011:  ill = 1'b1;
            default: ill = 1'b0;
        endcase
        return ill;
    endfunction

    // BLTU/BGEU run the comparator in unsigned mode, everything else signed
    function automatic logic f3_unsigned(input logic [2:0] f3);
        logic uns;
        case (f3)
            3'b110:  uns = 1'b1;
            3'b111:  uns = 1'b1;
            default: uns = 1'b0;
        endcase
        return uns;
    endfunction

    // breq is only looked at for BEQ/BNE, which always run in signed mode
    function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
        logic tk;
        case (f3)
            3'b000:  tk = eq;
            3'b001:  tk = ~eq;
            3'b100:  tk = lt;
            3'b101:  tk = ~lt;
            3'b110:  tk = lt;
            3'b111:  tk = ~lt;
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

    state_t      state_q, state_d;
    logic        br_ready_q, br_ready_d;
    logic        slt_ready_q, slt_ready_d;
    logic        last_slt_q, last_slt_d;
    logic        req_is_br_q, req_is_br_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        cmp_brun_q, cmp_brun_d;
    logic [31:0] cmp_in_a_q, cmp_in_a_d;
    logic [31:0] cmp_in_b_q, cmp_in_b_d;
    logic        br_resp_valid_q, br_resp_valid_d;
    logic        br_taken_q, br_taken_d;
    logic        br_illegal_q, br_illegal_d;
    logic        slt_resp_valid_q, slt_resp_valid_d;
    logic [31:0] slt_result_q, slt_result_d;
    logic [15:0] br_taken_cnt_q, br_taken_cnt_d;

    logic        grant_br_s;
    logic        grant_slt_s;
    logic        accept_br_s;
    logic        accept_slt_s;
    logic        taken_s;

    assign accept_br_s  = br_req_valid & br_ready_q;
    assign accept_slt_s = slt_req_valid & slt_ready_q;
    assign taken_s      = f3_taken(funct3_q, cmp_breq, cmp_brlt);

    // Round-robin grant: a lone requester wins, on contention the one not served last wins
    always_comb begin
        grant_br_s  = 1'b0;
        grant_slt_s = 1'b0;
        if (br_req_valid && (!slt_req_valid || last_slt_q)) begin
            grant_br_s = 1'b1;
        end else if (slt_req_valid) begin
            grant_slt_s = 1'b1;
        end else begin
            grant_br_s  = 1'b0;
            grant_slt_s = 1'b0;
        end
    end

    // Sequencer next-state: accept in IDLE, sample flags in CMP, re-arm readys in RESP
    always_comb begin
        state_d          = state_q;
        br_ready_d       = 1'b0;
        slt_ready_d      = 1'b0;
        last_slt_d       = last_slt_q;
        req_is_br_d      = req_is_br_q;
        funct3_d         = funct3_q;
        cmp_brun_d       = cmp_brun_q;
        cmp_in_a_d       = cmp_in_a_q;
        cmp_in_b_d       = cmp_in_b_q;
        br_resp_valid_d  = 1'b0;
        br_taken_d       = br_taken_q;
        br_illegal_d     = br_illegal_q;
        slt_resp_valid_d = 1'b0;
        slt_result_d     = slt_result_q;
        br_taken_cnt_d   = br_taken_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_br_s) begin
                    state_d     = ST_CMP;
                    last_slt_d  = 1'b0;
                    req_is_br_d = 1'b1;
                    funct3_d    = br_funct3;
                    cmp_brun_d  = f3_unsigned(br_funct3);
                    cmp_in_a_d  = br_rs1;
                    cmp_in_b_d  = br_rs2;
                end else if (accept_slt_s) begin
                    state_d     = ST_CMP;
                    last_slt_d  = 1'b1;
                    req_is_br_d = 1'b0;
                    funct3_d    = 3'b000;
                    cmp_brun_d  = slt_unsigned;
                    cmp_in_a_d  = slt_rs1;
                    cmp_in_b_d  = slt_rs2;
                end else begin
                    br_ready_d  = grant_br_s;
                    slt_ready_d = grant_slt_s;
                end
            end
            ST_CMP: begin
                state_d = ST_RESP;
                if (req_is_br_q) begin
                    br_resp_valid_d = 1'b1;
                    br_taken_d      = taken_s;
                    br_illegal_d    = f3_illegal(funct3_q);
                    if (taken_s) begin
                        br_taken_cnt_d = br_taken_cnt_q + 16'd1;
                    end else begin
                        br_taken_cnt_d = br_taken_cnt_q;
                    end
                end else begin
                    slt_resp_valid_d = 1'b1;
                    slt_result_d     = {31'd0, cmp_brlt};
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                br_ready_d  = grant_br_s;
                slt_ready_d = grant_slt_s;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last-served pointer resets to SLT so branch wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            br_ready_q       <= 1'b0;
            slt_ready_q      <= 1'b0;
            last_slt_q       <= 1'b1;
            req_is_br_q      <= 1'b0;
            funct3_q         <= 3'b000;
            cmp_brun_q       <= 1'b0;
            cmp_in_a_q       <= 32'd0;
            cmp_in_b_q       <= 32'd0;
            br_resp_valid_q  <= 1'b0;
            br_taken_q       <= 1'b0;
            br_illegal_q     <= 1'b0;
            slt_resp_valid_q <= 1'b0;
            slt_result_q     <= 32'd0;
            br_taken_cnt_q   <= 16'd0;
        end else begin
            state_q          <= state_d;
            br_ready_q       <= br_ready_d;
            slt_ready_q      <= slt_ready_d;
            last_slt_q       <= last_slt_d;
            req_is_br_q      <= req_is_br_d;
            funct3_q         <= funct3_d;
            cmp_brun_q       <= cmp_brun_d;
            cmp_in_a_q       <= cmp_in_a_d;
            cmp_in_b_q       <= cmp_in_b_d;
            br_resp_valid_q  <= br_resp_valid_d;
            br_taken_q       <= br_taken_d;
            br_illegal_q     <= br_illegal_d;
            slt_resp_valid_q <= slt_resp_valid_d;
            slt_result_q     <= slt_result_d;
            br_taken_cnt_q   <= br_taken_cnt_d;
        end
    end

    assign br_req_ready   = br_ready_q;
    assign slt_req_ready  = slt_ready_q;
    assign br_resp_valid  = br_resp_valid_q;
    assign br_taken       = br_taken_q;
    assign br_illegal     = br_illegal_q;
    assign slt_resp_valid = slt_resp_valid_q;
    assign slt_result     = slt_result_q;
    assign cmp_brun       = cmp_brun_q;
    assign cmp_in_a       = cmp_in_a_q;
    assign cmp_in_b       = cmp_in_b_q;
    assign br_taken_cnt   = br_taken_cnt_q;

endmodule

// File: tb/tb_branch_cmp_sched.sv
// Bench for branch_cmp_sched: directed requests, a comparator model driving the
// flags, a cycle-level reference model of the scheduler, and literal checks.
module tb_branch_cmp_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_req_valid, br_req_ready;
    logic [2:0]  br_funct3;
    logic [31:0] br_rs1, br_rs2;
    logic        br_resp_valid, br_taken, br_illegal;
    logic        slt_req_valid, slt_req_ready, slt_unsigned;
    logic [31:0] slt_rs1, slt_rs2;
    logic        slt_resp_valid;
    logic [31:0] slt_result;
    logic        cmp_brun;
    logic [31:0] cmp_in_a, cmp_in_b;
    logic        cmp_breq, cmp_brlt;
    logic [15:0] br_taken_cnt;

    always #5 clk = ~clk;

    branch_cmp_sched dut (
        .clk(clk), .rst_n(rst_n),
        .br_req_valid(br_req_valid), .br_req_ready(br_req_ready),
        .br_funct3(br_funct3), .br_rs1(br_rs1), .br_rs2(br_rs2),
        .br_resp_valid(br_resp_valid), .br_taken(br_taken), .br_illegal(br_illegal),
        .slt_req_valid(slt_req_valid), .slt_req_ready(slt_req_ready),
        .slt_unsigned(slt_unsigned), .slt_rs1(slt_rs1), .slt_rs2(slt_rs2),
        .slt_resp_valid(slt_resp_valid), .slt_result(slt_result),
        .cmp_brun(cmp_brun), .cmp_in_a(cmp_in_a), .cmp_in_b(cmp_in_b),
        .cmp_breq(cmp_breq), .cmp_brlt(cmp_brlt),
        .br_taken_cnt(br_taken_cnt)
    );

    // Shared comparator; breq is deliberately wrong in unsigned mode (it is not updated there)
    assign cmp_breq = cmp_brun ? (cmp_in_a != cmp_in_b) : (cmp_in_a == cmp_in_b);
    assign cmp_brlt = cmp_brun ? (cmp_in_a < cmp_in_b) : ($signed(cmp_in_a) < $signed(cmp_in_b));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc_tag[$];
    int acc_cyc[$];
    logic [15:0] cnt_ofs = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Branch outcome straight from the ISA definition
    function automatic logic exp_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    logic        m_rdy_br, m_rdy_slt, m_last_slt;
    int          m_since;
    logic        p_br, p_uns;
    logic [2:0]  p_f3;
    logic [31:0] p_a, p_b;
    logic        e_brv, e_taken, e_ill, e_sltv, e_brun;
    logic [31:0] e_slt, e_a, e_b;
    logic [15:0] e_cnt, e_cnt_tot;
    logic        m_acc_br, m_acc_slt, m_grant_br, m_grant_slt, m_free;

    assign m_acc_br    = br_req_valid && m_rdy_br;
    assign m_acc_slt   = slt_req_valid && m_rdy_slt;
    assign m_grant_br  = br_req_valid && (!slt_req_valid || m_last_slt);
    assign m_grant_slt = slt_req_valid && !m_grant_br;
    // two or more edges after the last accept, the scheduler is offering grants again
    assign m_free      = !(m_acc_br || m_acc_slt) && (m_since >= 1);
    assign e_cnt_tot   = e_cnt + cnt_ofs;

    // Model update: one accept occupies three cycles; the result appears one edge after accept
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy_br <= 1'b0; m_rdy_slt <= 1'b0; m_last_slt <= 1'b1; m_since <= 99;
            p_br <= 1'b0; p_uns <= 1'b0; p_f3 <= 3'd0; p_a <= 32'd0; p_b <= 32'd0;
            e_brv <= 1'b0; e_taken <= 1'b0; e_ill <= 1'b0; e_sltv <= 1'b0; e_brun <= 1'b0;
            e_slt <= 32'd0; e_a <= 32'd0; e_b <= 32'd0; e_cnt <= 16'd0;
        end else begin
            e_brv  <= (m_since == 0) && p_br;
            e_sltv <= (m_since == 0) && !p_br;
            if (m_since == 0 && p_br) begin
                e_taken <= exp_taken(p_f3, p_a, p_b);
                e_ill   <= (p_f3 == 3'd2) || (p_f3 == 3'd3);
                e_cnt   <= e_cnt + (exp_taken(p_f3, p_a, p_b) ? 16'd1 : 16'd0);
            end
            if (m_since == 0 && !p_br)
                e_slt <= {31'd0, (p_uns ? (p_a < p_b) : ($signed(p_a) < $signed(p_b)))};
            if (m_acc_br) begin
                p_br <= 1'b1; p_f3 <= br_funct3; p_a <= br_rs1; p_b <= br_rs2;
                e_a <= br_rs1; e_b <= br_rs2; e_brun <= (br_funct3 == 3'd6) || (br_funct3 == 3'd7);
                m_last_slt <= 1'b0;
            end else if (m_acc_slt) begin
                p_br <= 1'b0; p_uns <= slt_unsigned; p_a <= slt_rs1; p_b <= slt_rs2;
                e_a <= slt_rs1; e_b <= slt_rs2; e_brun <= slt_unsigned;
                m_last_slt <= 1'b1;
            end
            m_since   <= (m_acc_br || m_acc_slt) ? 0 : ((m_since < 99) ? m_since + 1 : m_since);
            m_rdy_br  <= m_free && m_grant_br;
            m_rdy_slt <= m_free && m_grant_slt;
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        chk("br_req_ready", {31'd0, br_req_ready}, {31'd0, m_rdy_br});
        chk("slt_req_ready", {31'd0, slt_req_ready}, {31'd0, m_rdy_slt});
        chk("two_readys", {31'd0, br_req_ready & slt_req_ready}, 32'd0);
        chk("br_resp_valid", {31'd0, br_resp_valid}, {31'd0, e_brv});
        chk("br_taken", {31'd0, br_taken}, {31'd0, e_taken});
        chk("br_illegal", {31'd0, br_illegal}, {31'd0, e_ill});
        chk("slt_resp_valid", {31'd0, slt_resp_valid}, {31'd0, e_sltv});
        chk("slt_result", slt_result, e_slt);
        chk("cmp_brun", {31'd0, cmp_brun}, {31'd0, e_brun});
        chk("cmp_in_a", cmp_in_a, e_a);
        chk("cmp_in_b", cmp_in_b, e_b);
        chk("br_taken_cnt", {16'd0, br_taken_cnt}, {16'd0, e_cnt_tot});
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        br_req_valid = 1'b1; br_funct3 = f3; br_rs1 = a; br_rs2 = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (br_req_ready) begin
                @(posedge clk); #1;
                acc_tag.push_back(0); acc_cyc.push_back(cyc);
                br_req_valid = 1'b0;
                return;
            end
        end
        chk("br_accept_timeout", {31'd0, br_req_ready}, 32'd1);
        br_req_valid = 1'b0;
    endtask

    task automatic do_slt(input logic uns, input logic [31:0] a, input logic [31:0] b);
        slt_req_valid = 1'b1; slt_unsigned = uns; slt_rs1 = a; slt_rs2 = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (slt_req_ready) begin
                @(posedge clk); #1;
                acc_tag.push_back(1); acc_cyc.push_back(cyc);
                slt_req_valid = 1'b0;
                return;
            end
        end
        chk("slt_accept_timeout", {31'd0, slt_req_ready}, 32'd1);
        slt_req_valid = 1'b0;
    endtask

    task automatic run_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic xt, input logic xi, input logic xu);
        bit got;
        do_br(f3, a, b);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (br_resp_valid) got = 1'b1;
        end
        if (!got) chk("br_resp_timeout", {31'd0, br_resp_valid}, 32'd1);
        else begin
            chk("lit_br_latency", cyc - acc_cyc[$], 32'd1);
            chk("lit_br_taken", {31'd0, br_taken}, {31'd0, xt});
            chk("lit_br_illegal", {31'd0, br_illegal}, {31'd0, xi});
            chk("lit_cmp_brun", {31'd0, cmp_brun}, {31'd0, xu});
            @(negedge clk);
            chk("lit_br_strobe_one_cycle", {31'd0, br_resp_valid}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_slt(input logic uns, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] xr);
        bit got;
        do_slt(uns, a, b);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (slt_resp_valid) got = 1'b1;
        end
        if (!got) chk("slt_resp_timeout", {31'd0, slt_resp_valid}, 32'd1);
        else begin
            chk("lit_slt_result", slt_result, xr);
            chk("lit_slt_brun", {31'd0, cmp_brun}, {31'd0, uns});
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, {30'd0, br_req_ready, slt_req_ready}, 32'd0);
        chk({tag, "_strobes"}, {30'd0, br_resp_valid, slt_resp_valid}, 32'd0);
        chk({tag, "_br_data"}, {30'd0, br_taken, br_illegal}, 32'd0);
        chk({tag, "_slt_result"}, slt_result, 32'd0);
        chk({tag, "_cmp_brun"}, {31'd0, cmp_brun}, 32'd0);
        chk({tag, "_cmp_a"}, cmp_in_a, 32'd0);
        chk({tag, "_cmp_b"}, cmp_in_b, 32'd0);
        chk({tag, "_cnt"}, {16'd0, br_taken_cnt}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        br_req_valid = 1'b0; br_funct3 = 3'd0; br_rs1 = 32'd0; br_rs2 = 32'd0;
        slt_req_valid = 1'b0; slt_unsigned = 1'b0; slt_rs1 = 32'd0; slt_rs2 = 32'd0;
        #1 chk_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        run_br(3'b000, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
        chk("lit_cnt_after_beq", {16'd0, br_taken_cnt}, 32'd1);
        run_br(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        run_br(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        run_br(3'b111, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 1'b1);
        run_slt(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
        run_slt(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
        run_br(3'b010, 32'd7, 32'd7, 1'b0, 1'b1, 1'b0);
        chk("lit_cnt_after_illegal", {16'd0, br_taken_cnt}, 32'd3);
        run_br(3'b101, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0);

        // reset while the comparator cycle is in progress
        do_br(3'b000, 32'd9, 32'd9);
        #2 rst_n = 1'b0;
        #1 chk_zero("midcmp_reset");
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_br(3'b001, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
        chk("lit_cnt_after_bne", {16'd0, br_taken_cnt}, 32'd1);

        // both requesters valid out of reset: branch, SLT, branch, SLT
        rst_n = 1'b0;
        br_req_valid = 1'b1; slt_req_valid = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        acc_tag.delete(); acc_cyc.delete();
        fork
            begin do_br(3'b000, 32'd1, 32'd1); do_br(3'b101, 32'd2, 32'd1); end
            begin do_slt(1'b0, 32'd5, 32'd6); do_slt(1'b1, 32'd6, 32'd5); end
        join
        chk("lit_rr_count", acc_tag.size(), 32'd4);
        if (acc_tag.size() == 4) begin
            chk("lit_rr_first", acc_tag[0], 32'd0);
            chk("lit_rr_second", acc_tag[1], 32'd1);
            chk("lit_rr_third", acc_tag[2], 32'd0);
            chk("lit_rr_fourth", acc_tag[3], 32'd1);
            chk("lit_rr_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
            chk("lit_rr_gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
        end
        repeat (4) @(posedge clk);
        #1;

        // counter wrap: preload near the top, then three taken branches cross 0xFFFF
        force dut.br_taken_cnt_q = 16'hFFFD;
        cnt_ofs = 16'hFFFD - e_cnt;
        @(posedge clk); #1;
        release dut.br_taken_cnt_q;
        run_br(3'b000, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
        chk("lit_cnt_fffe", {16'd0, br_taken_cnt}, 32'h0000_FFFE);
        run_br(3'b000, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        chk("lit_cnt_ffff", {16'd0, br_taken_cnt}, 32'h0000_FFFF);
        run_br(3'b000, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
        chk("lit_cnt_wrap", {16'd0, br_taken_cnt}, 32'h0000_0000);
        run_br(3'b000, 32'd4, 32'd4, 1'b1, 1'b0, 1'b0);
        chk("lit_cnt_after_wrap", {16'd0, br_taken_cnt}, 32'h0000_0001);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
